ibuf2ddr: RTL and testbench
===========================

Name: ibuf2ddr

Overview:
- Read-back path for the PE index buffers: the inverse of the DDR-to-index-buffer loader.
- Reads conf_idx_num index entries from one selected PE's index buffer and packs IDX_BATCH = DDR_W/(IDX_W*2) entries per DDR word.
- Streams the packed words to the DDR write path with valid/ready handshake and a last flag.
- Used for debug dump and for checkpointing sparse index state back to DDR.

Parameters:
- IDX_DEPTH, 256, index buffer depth (entries per PE).
- ADDR_W, bw(IDX_DEPTH), index buffer address width.
- PE_NUM, 32, number of PEs / index buffers.
- PE_SEL_W, bw(PE_NUM), width of the PE select field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- conf_valid  in  1  configuration request.
- conf_ready  out  1  high when idle and able to accept a configuration.
- conf_mode  in  4  layer mode; [2:1]==2'b01 selects half-swap.
- conf_idx_num  in  8  number of index entries to read (0..255).
- conf_pe_sel  in  PE_SEL_W  source PE index.
- idx_rd_en  out  PE_NUM  one-hot read enable to the index buffers.
- idx_rd_addr  out  ADDR_W  read address, shared by all buffers.
- idx_rd_data  in  PE_NUM*IDX_W*2  concatenated buffer read data; PE p occupies bits [p*IDX_W*2 +: IDX_W*2]; 1-cycle read latency.
- ddr_data  out  DDR_W  packed output word.
- ddr_valid  out  1  output word valid.
- ddr_last  out  1  marks the final word of the transfer.
- ddr_ready  in  1  downstream accept.

Behaviour:
- Reset values: conf_ready=1, ddr_valid=0, ddr_last=0, ddr_data=0, idx_rd_en=0, idx_rd_addr=0. FSM goes to IDLE and the word FIFO is emptied.
- Reset mid-transfer aborts the transfer immediately. Partial words are discarded.
- FSM states: IDLE, READ, DRAIN.
- IDLE: conf_ready=1.
  - On conf_valid&&conf_ready, latch mode, idx_num, pe_sel; clear the read counter and lane counter.
  - If conf_idx_num==0, stay in IDLE; no output is produced.
  - Otherwise go to READ.
- conf_ready=0 in READ and DRAIN. conf_valid is ignored there.
- READ: issue at most one read per cycle.
  - idx_rd_addr = read counter.
  - idx_rd_en = one-hot(pe_sel). If pe_sel>=PE_NUM, no enable bit is set and the returned data is treated as zero.
  - The read counter increments on each issue.
  - When the read counter reaches idx_num-1 and that read issues, go to DRAIN.
- Read data is captured one cycle after issue from the latched PE slice.
- If mode[2:1]==2'b01, the IDX_W halves of each entry are swapped before packing.
- Packing: entry k lands in lane k mod IDX_BATCH. Lane 0 occupies the LSBs.
- A word is pushed into a 2-deep word FIFO when its lane IDX_BATCH-1 is filled, or when the final entry is filled.
- Unfilled lanes of the final word are zero. The final word carries last=1.
- Issue throttle: a read that opens a new word (lane 0) issues only when fifo_count + open_word < 2. Reads into an already-open word always issue. The FIFO therefore never overflows.
- DRAIN: wait until the final entry is captured and the FIFO is empty (last word accepted), then go to IDLE. conf_ready rises the cycle after the last handshake.
- Output handshake:
  - ddr_valid = FIFO non-empty; ddr_data and ddr_last are the FIFO head.
  - Head is popped on ddr_valid&&ddr_ready.
  - ddr_data and ddr_last are held stable while ddr_valid&&!ddr_ready.
  - Push and pop in the same cycle are allowed.
- Latency with ddr_ready=1:
  - Handshake at cycle 0.
  - First read issues in cycle 1.
  - First ddr_valid in cycle IDX_BATCH+2.
  - Sustained rate: one entry per cycle, one word per IDX_BATCH cycles.
- Word count per transfer is ceil(idx_num/IDX_BATCH).

Decomposition:
- DDR_W, IDX_W and bw() come from GLOBAL_PARAM.
- Add IDX_BATCH and the mode-field constant MODE_SWAP=2'b01 on conf_mode[2:1] to GLOBAL_PARAM, so loader and reader share them.
- Add an FSM state enum (IDLE/READ/DRAIN) to GLOBAL_PARAM.
- One sub-module: ddr_word_fifo, a 2-deep {last, DDR_W} register FIFO with count output.

Test Plan:
Bench config: DDR_W=64, IDX_W=8, IDX_BATCH=4. Buffer entry a of PE p holds 16'h(p)(a).
1. N=8, pe_sel=3, ready=1:
   - idx_rd_en=32'h8 for addr 0..7.
   - Two words: 64'h0303_0302_0301_0300 then 64'h0307_0306_0305_0304.
   - last=1 only on the second word; first valid at cycle 6; conf_ready=1 after.
2. N=5, pe_sel=0 -> word1=64'h0000_0000_0000_0004, last=1.
3. N=64, ddr_ready low 10 cycles then random toggling:
   - Data/last stable while stalled; reads stall with at most 2 words buffered.
   - 16 words in order, no loss or duplication.
4. conf_mode=4'b0010, entry 16'hAB12 -> lane holds 16'h12AB. With conf_mode=4'b0000 the lane holds 16'hAB12.
5. N=0 -> no idx_rd_en, no ddr_valid; conf_ready stays 1 and the next config is accepted.
6. Assert rst after the first word of an N=16 transfer:
   - Next cycle all outputs are at reset values.
   - A new N=4 config yields exactly one correct word with last=1.

Source files
------------

// File: rtl/ibuf2ddr_pkg.sv
// Shared constants for the DDR <-> index buffer movers.
// Holds bus widths, packing factor, mode field encoding and FSM states.
package ibuf2ddr_pkg;

  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DDR_W     = 64;
  localparam int IDX_W     = 8;
  localparam int IDX_BATCH = DDR_W / (IDX_W * 2);

  // conf_mode[2:1] value selecting half-swap of each entry
  localparam logic [1:0] MODE_SWAP = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ddr_word_fifo.sv
// Two-entry register FIFO for packed DDR words {last, data}.
// Ports: push/din in, pop/dout out (head), count = occupancy 0..2.
module ddr_word_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] s0_q, s0_d;
  logic [W-1:0] s1_q, s1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   wi;
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    s0_d    = s0_q;
    s1_d    = s1_q;
    // slot the new word lands in, after any pop shifts
    wi      = cnt_q - {1'b0, pop_ok};
    if (pop_ok) s0_d = s1_q;
    if (push_ok) begin
      if (wi == 2'd0) s0_d = din;
      else            s1_d = din;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q  <= '0;
      s1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = s0_q;
  assign count = cnt_q;

endmodule

// File: rtl/ibuf2ddr.sv
// Reads one PE's index buffer and packs entries into DDR words.
// conf_* request in; idx_rd_* buffer port; ddr_* valid/ready/last stream out.
module ibuf2ddr
  import ibuf2ddr_pkg::*;
#(
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = bw(IDX_DEPTH),
  parameter int PE_NUM    = 32,
  parameter int PE_SEL_W  = bw(PE_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      conf_valid,
  output logic                      conf_ready,
  input  logic [3:0]                conf_mode,
  input  logic [7:0]                conf_idx_num,
  input  logic [PE_SEL_W-1:0]       conf_pe_sel,
  output logic [PE_NUM-1:0]         idx_rd_en,
  output logic [ADDR_W-1:0]         idx_rd_addr,
  input  logic [PE_NUM*IDX_W*2-1:0] idx_rd_data,
  output logic [DDR_W-1:0]          ddr_data,
  output logic                      ddr_valid,
  output logic                      ddr_last,
  input  logic                      ddr_ready
);

  localparam int EW     = IDX_W * 2;
  localparam int LANE_W = bw(IDX_BATCH);
  localparam logic [LANE_W-1:0] LANE_END = LANE_W'(IDX_BATCH - 1);

  state_e              state_q, state_d;
  logic                swap_q, swap_d;
  logic [7:0]          num_q, num_d;
  logic [PE_SEL_W-1:0] pe_q, pe_d;
  logic [7:0]          rd_cnt_q, rd_cnt_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                open_q, open_d;
  logic                cap_vld_q, cap_vld_d;
  logic [LANE_W-1:0]   cap_lane_q, cap_lane_d;
  logic                cap_last_q, cap_last_d;
  logic [DDR_W-1:0]    word_q, word_d;

  logic                start, can_open, issue, last_iss;
  logic                push, pop, empty_nxt;
  logic [EW-1:0]       ent;
  logic [DDR_W-1:0]    word_nxt;
  logic [DDR_W:0]      head;
  logic [1:0]          fifo_cnt;
  logic                unused_mode;

  assign unused_mode = ^{conf_mode[3], conf_mode[0]};

  always_comb begin
    start    = conf_valid && (state_q == S_IDLE);
    // a new word may open only if it plus queued words fit in the FIFO
    can_open = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !open_q);
    issue    = (state_q == S_READ) && ((lane_q != '0) || can_open);
    last_iss = issue && (rd_cnt_q == num_q - 8'd1);
    idx_rd_en = '0;
    for (int p = 0; p < PE_NUM; p++)
      if (issue && (pe_q == PE_SEL_W'(p))) idx_rd_en[p] = 1'b1;
    idx_rd_addr = (state_q == S_READ) ? ADDR_W'(rd_cnt_q) : '0;
  end

  always_comb begin
    ent = '0;
    for (int p = 0; p < PE_NUM; p++)
      if (pe_q == PE_SEL_W'(p)) ent = idx_rd_data[p*EW +: EW];
    if (swap_q) ent = {ent[IDX_W-1:0], ent[EW-1:IDX_W]};
    // lane 0 starts a fresh word so unfilled lanes read as zero
    word_nxt = (cap_lane_q == '0) ? '0 : word_q;
    word_nxt[int'(cap_lane_q)*EW +: EW] = ent;
    push = cap_vld_q && ((cap_lane_q == LANE_END) || cap_last_q);
  end

  always_comb begin
    swap_d     = swap_q;
    num_d      = num_q;
    pe_d       = pe_q;
    rd_cnt_d   = rd_cnt_q;
    lane_d     = lane_q;
    open_d     = open_q;
    word_d     = cap_vld_q ? word_nxt : word_q;
    cap_vld_d  = issue;
    cap_lane_d = lane_q;
    cap_last_d = last_iss;
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
      lane_d   = (lane_q == LANE_END) ? '0 : lane_q + LANE_W'(1);
    end
    if (issue && (lane_q == '0)) open_d = 1'b1;
    else if (push)               open_d = 1'b0;
    if (start) begin
      swap_d   = (conf_mode[2:1] == MODE_SWAP);
      num_d    = conf_idx_num;
      pe_d     = conf_pe_sel;
      rd_cnt_d = '0;
      lane_d   = '0;
      open_d   = 1'b0;
    end
  end

  always_comb begin
    pop       = ddr_valid && ddr_ready;
    empty_nxt = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop);
    state_d   = state_q;
    unique case (state_q)
      S_IDLE:  if (start && (conf_idx_num != 8'd0)) state_d = S_READ;
      S_READ:  if (last_iss) state_d = S_DRAIN;
      S_DRAIN: if (!cap_vld_q && empty_nxt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      swap_q     <= 1'b0;
      num_q      <= '0;
      pe_q       <= '0;
      rd_cnt_q   <= '0;
      lane_q     <= '0;
      open_q     <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= '0;
      cap_last_q <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      swap_q     <= swap_d;
      num_q      <= num_d;
      pe_q       <= pe_d;
      rd_cnt_q   <= rd_cnt_d;
      lane_q     <= lane_d;
      open_q     <= open_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      cap_last_q <= cap_last_d;
      word_q     <= word_d;
    end
  end

  ddr_word_fifo #(.W(DDR_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cap_last_q, word_nxt}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt)
  );

  assign conf_ready = (state_q == S_IDLE);
  assign ddr_valid  = (fifo_cnt != 2'd0);
  assign ddr_data   = head[DDR_W-1:0];
  assign ddr_last   = ddr_valid && head[DDR_W];

endmodule

// File: tb/tb_ibuf2ddr.sv
// Directed bench for ibuf2ddr with a 1-cycle index buffer model.
// Entry a of PE p reads as {p, a}; ovr forces every entry to 16'hAB12.
module tb_ibuf2ddr;
  import ibuf2ddr_pkg::*;

  localparam int PE_NUM = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          conf_valid = 1'b0;
  logic          conf_ready;
  logic [3:0]    conf_mode = 4'd0;
  logic [7:0]    conf_idx_num = 8'd0;
  logic [4:0]    conf_pe_sel = 5'd0;
  logic [31:0]   idx_rd_en;
  logic [7:0]    idx_rd_addr;
  logic [511:0]  idx_rd_data = '0;
  logic [63:0]   ddr_data;
  logic          ddr_valid;
  logic          ddr_last;
  logic          ddr_ready = 1'b1;

  logic          ovr = 1'b0;
  logic [64:0]   words_q[$];
  logic [39:0]   rd_log[$];
  int            checks = 0;
  int            passes = 0;

  ibuf2ddr #(.IDX_DEPTH(256), .PE_NUM(PE_NUM)) dut (
    .clk          (clk),
    .rst          (rst),
    .conf_valid   (conf_valid),
    .conf_ready   (conf_ready),
    .conf_mode    (conf_mode),
    .conf_idx_num (conf_idx_num),
    .conf_pe_sel  (conf_pe_sel),
    .idx_rd_en    (idx_rd_en),
    .idx_rd_addr  (idx_rd_addr),
    .idx_rd_data  (idx_rd_data),
    .ddr_data     (ddr_data),
    .ddr_valid    (ddr_valid),
    .ddr_last     (ddr_last),
    .ddr_ready    (ddr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int p = 0; p < PE_NUM; p++)
      if (idx_rd_en[p])
        idx_rd_data[p*16 +: 16] <= ovr ? 16'hAB12 : {8'(p), idx_rd_addr};
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (ddr_valid && ddr_ready) words_q.push_back({ddr_last, ddr_data});
      if (idx_rd_en != '0) rd_log.push_back({idx_rd_en, idx_rd_addr});
    end
  end

  function automatic logic [63:0] exp_word(input int pe, input int base,
                                           input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 4; k++)
      if (base + k < n) w[k*16 +: 16] = {8'(pe), 8'(base + k)};
    return w;
  endfunction

  task automatic configure(input int n, input int pe, input logic [3:0] mode);
    @(negedge clk);
    conf_valid   = 1'b1;
    conf_idx_num = 8'(n);
    conf_pe_sel  = 5'(pe);
    conf_mode    = mode;
    @(negedge clk);
    conf_valid   = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      if (words_q.size() >= n && conf_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (conf_ready !== 1'b1) $display("FAIL rst_conf_ready got %b exp 1", conf_ready); else passes++;
    checks++; if (ddr_valid !== 1'b0) $display("FAIL rst_ddr_valid got %b exp 0", ddr_valid); else passes++;
    checks++; if (ddr_last !== 1'b0) $display("FAIL rst_ddr_last got %b exp 0", ddr_last); else passes++;
    checks++; if (ddr_data !== 64'd0) $display("FAIL rst_ddr_data got %h exp 0", ddr_data); else passes++;
    checks++; if (idx_rd_en !== 32'd0) $display("FAIL rst_rd_en got %h exp 0", idx_rd_en); else passes++;
    checks++; if (idx_rd_addr !== 8'd0) $display("FAIL rst_rd_addr got %h exp 0", idx_rd_addr); else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    ddr_ready = 1'b1;
    words_q.delete();
    rd_log.delete();
    configure(8, 3, 4'b0000);
    cyc = 1;
    while (!ddr_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 6) $display("FAIL basic_latency got %0d exp 6", cyc); else passes++;
    wait_words(2, ok);
    checks++; if (ok !== 1'b1) $display("FAIL basic_timeout got %b exp 1", ok); else passes++;
    checks++; if (words_q.size() !== 2) $display("FAIL basic_count got %0d exp 2", words_q.size()); else passes++;
    checks++; if (words_q[0] !== {1'b0, 64'h0303_0302_0301_0300})
      $display("FAIL basic_word0 got %h exp %h", words_q[0], {1'b0, 64'h0303_0302_0301_0300}); else passes++;
    checks++; if (words_q[1] !== {1'b1, 64'h0307_0306_0305_0304})
      $display("FAIL basic_word1 got %h exp %h", words_q[1], {1'b1, 64'h0307_0306_0305_0304}); else passes++;
    checks++; if (rd_log.size() !== 8) $display("FAIL basic_reads got %0d exp 8", rd_log.size()); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_log[i] !== {32'h8, 8'(i)})
        $display("FAIL basic_rd%0d got %h exp %h", i, rd_log[i], {32'h8, 8'(i)});
      else passes++;
    end
    @(negedge clk);
    checks++; if (conf_ready !== 1'b1) $display("FAIL basic_ready_after got %b exp 1", conf_ready); else passes++;
  endtask

  task automatic test_partial();
    bit ok;
    words_q.delete();
    rd_log.delete();
    configure(5, 0, 4'b0000);
    wait_words(2, ok);
    checks++; if (ok !== 1'b1) $display("FAIL partial_timeout got %b exp 1", ok); else passes++;
    checks++; if (words_q[0] !== {1'b0, 64'h0003_0002_0001_0000})
      $display("FAIL partial_word0 got %h exp %h", words_q[0], {1'b0, 64'h0003_0002_0001_0000}); else passes++;
    checks++; if (words_q[1] !== {1'b1, 64'h0000_0000_0000_0004})
      $display("FAIL partial_word1 got %h exp %h", words_q[1], {1'b1, 64'h0000_0000_0000_0004}); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int stab_bad, buf_bad, bad_words;
    logic pv, pr, pl;
    logic [63:0] pd;
    logic [64:0] exp;
    stab_bad = 0;
    buf_bad  = 0;
    bad_words = 0;
    ok = 1'b0;
    words_q.delete();
    rd_log.delete();
    ddr_ready = 1'b0;
    configure(64, 5, 4'b0000);
    pv = ddr_valid; pr = 1'b0; pd = ddr_data; pl = ddr_last;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pv && !pr && (!ddr_valid || ddr_data !== pd || ddr_last !== pl)) stab_bad++;
      if (rd_log.size() > 4 * words_q.size() + 8) buf_bad++;
      if (c == 11) begin
        checks++; if (rd_log.size() !== 8) $display("FAIL bp_stall_reads got %0d exp 8", rd_log.size()); else passes++;
      end
      if (c >= 12 && words_q.size() >= 16 && conf_ready) begin
        ok = 1'b1;
        break;
      end
      if (c >= 11) ddr_ready = 1'($urandom_range(0, 1));
      pv = ddr_valid; pr = ddr_ready; pd = ddr_data; pl = ddr_last;
    end
    ddr_ready = 1'b1;
    checks++; if (ok !== 1'b1) $display("FAIL bp_timeout got %b exp 1", ok); else passes++;
    checks++; if (stab_bad !== 0) $display("FAIL bp_stable got %0d exp 0", stab_bad); else passes++;
    checks++; if (buf_bad !== 0) $display("FAIL bp_buffered got %0d exp 0", buf_bad); else passes++;
    checks++; if (words_q.size() !== 16) $display("FAIL bp_count got %0d exp 16", words_q.size()); else passes++;
    for (int i = 0; i < 16; i++) begin
      exp = {(i == 15), exp_word(5, 4 * i, 64)};
      if (words_q[i] !== exp) begin
        bad_words++;
        $display("FAIL bp_word%0d got %h exp %h", i, words_q[i], exp);
      end
    end
    checks++; if (bad_words !== 0) $display("FAIL bp_words got %0d bad exp 0", bad_words); else passes++;
  endtask

  task automatic test_swap();
    bit ok;
    ovr = 1'b1;
    words_q.delete();
    configure(4, 1, 4'b0010);
    wait_words(1, ok);
    checks++; if (words_q[0] !== {1'b1, 64'h12AB_12AB_12AB_12AB})
      $display("FAIL swap_on got %h exp %h", words_q[0], {1'b1, 64'h12AB_12AB_12AB_12AB}); else passes++;
    words_q.delete();
    configure(4, 1, 4'b0000);
    wait_words(1, ok);
    checks++; if (words_q[0] !== {1'b1, 64'hAB12_AB12_AB12_AB12})
      $display("FAIL swap_off got %h exp %h", words_q[0], {1'b1, 64'hAB12_AB12_AB12_AB12}); else passes++;
    ovr = 1'b0;
  endtask

  task automatic test_zero();
    bit ok;
    int bad;
    bad = 0;
    words_q.delete();
    rd_log.delete();
    configure(0, 4, 4'b0000);
    repeat (10) begin
      @(negedge clk);
      if (!conf_ready || ddr_valid) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL zero_idle got %0d exp 0", bad); else passes++;
    checks++; if (rd_log.size() !== 0) $display("FAIL zero_reads got %0d exp 0", rd_log.size()); else passes++;
    configure(4, 2, 4'b0000);
    wait_words(1, ok);
    checks++; if (words_q.size() !== 1) $display("FAIL zero_next_count got %0d exp 1", words_q.size()); else passes++;
    checks++; if (words_q[0] !== {1'b1, 64'h0203_0202_0201_0200})
      $display("FAIL zero_next_word got %h exp %h", words_q[0], {1'b1, 64'h0203_0202_0201_0200}); else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b;
    words_q.delete();
    configure(16, 7, 4'b0000);
    b = 0;
    while (words_q.size() < 1 && b < 200) begin
      @(negedge clk);
      b++;
    end
    checks++; if (words_q[0] !== {1'b0, 64'h0703_0702_0701_0700})
      $display("FAIL mid_first got %h exp %h", words_q[0], {1'b0, 64'h0703_0702_0701_0700}); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (conf_ready !== 1'b1) $display("FAIL mid_conf_ready got %b exp 1", conf_ready); else passes++;
    checks++; if (ddr_valid !== 1'b0) $display("FAIL mid_ddr_valid got %b exp 0", ddr_valid); else passes++;
    checks++; if (ddr_last !== 1'b0) $display("FAIL mid_ddr_last got %b exp 0", ddr_last); else passes++;
    checks++; if (ddr_data !== 64'd0) $display("FAIL mid_ddr_data got %h exp 0", ddr_data); else passes++;
    checks++; if (idx_rd_en !== 32'd0) $display("FAIL mid_rd_en got %h exp 0", idx_rd_en); else passes++;
    checks++; if (idx_rd_addr !== 8'd0) $display("FAIL mid_rd_addr got %h exp 0", idx_rd_addr); else passes++;
    rst = 1'b0;
    words_q.delete();
    rd_log.delete();
    configure(4, 9, 4'b0000);
    wait_words(1, ok);
    repeat (10) @(negedge clk);
    checks++; if (words_q.size() !== 1) $display("FAIL mid_new_count got %0d exp 1", words_q.size()); else passes++;
    checks++; if (words_q[0] !== {1'b1, 64'h0903_0902_0901_0900})
      $display("FAIL mid_new_word got %h exp %h", words_q[0], {1'b1, 64'h0903_0902_0901_0900}); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_swap();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
